// File: rtl/pika_pkg.sv
// Shared PikaCPU types and constants: register file geometry, word type,
// CPSR flag positions and the PC step helper used by the architectural state.
package pika_pkg;

    localparam int REG_NUM_W = 4;
    localparam int NUM_REGS  = 16;
    localparam int WORD_W    = 32;
    localparam int PC_STEP   = 4;

    localparam int CPSR_N = 31;
    localparam int CPSR_Z = 30;
    localparam int CPSR_C = 29;
    localparam int CPSR_V = 28;

    localparam int PEND_W = 2;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [REG_NUM_W-1:0] reg_num_t;
    typedef logic [PEND_W-1:0]    pend_cnt_t;

    // Sequential fetch address; wraps modulo 2^32 by construction.
    function automatic word_t pc_increment(input word_t pc);
        return pc + word_t'(PC_STEP);
    endfunction

endpackage

// File: rtl/pending_counter.sv
// Per-register outstanding-write counter: saturating 2-bit up/down count
// with synchronous clear and a combinational underflow indication.
module pending_counter
    import pika_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      inc,
    input  logic      dec,
    input  logic      clr,
    output pend_cnt_t count,
    output logic      underflow
);

    localparam pend_cnt_t CNT_MAX  = 2'd3;
    localparam pend_cnt_t CNT_ZERO = 2'd0;

    pend_cnt_t count_q;
    pend_cnt_t count_d;

    // Next count: clear wins, simultaneous inc/dec cancel, both ends saturate.
    always_comb begin
        count_d   = count_q;
        underflow = dec & ~inc & (count_q == CNT_ZERO);
        if (clr) begin
            count_d = CNT_ZERO;
        end else if (inc & ~dec) begin
            if (count_q == CNT_MAX) begin
                count_d = count_q;
            end else begin
                count_d = count_q + 2'd1;
            end
        end else if (dec & ~inc) begin
            if (count_q == CNT_ZERO) begin
                count_d = count_q;
            end else begin
                count_d = count_q - 2'd1;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/arch_state.sv
// PikaCPU architectural state: general registers, CPSR and PC updated from
// writeback, bypassed decode read ports and the RAW/WAW pending-write scoreboard.
module arch_state
    import pika_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MAX_PENDING = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wb_reg_num,
    input  logic [31:0] wb_reg_value,
    input  logic        wb_reg_write_en,
    input  logic [31:0] wb_cpsr_value,
    input  logic        wb_cpsr_write_en,
    input  logic [31:0] wb_pc_value,
    input  logic        wb_pc_write_en,
    input  logic        pc_advance,
    output logic [31:0] pc_out,
    output logic [31:0] cpsr_out,
    input  logic [3:0]  rs_num,
    input  logic [3:0]  rt_num,
    output logic [31:0] rs_value,
    output logic [31:0] rt_value,
    input  logic        issue_valid,
    input  logic        issue_writes_rd,
    input  logic [3:0]  issue_rd_num,
    output logic        issue_stall,
    input  logic        flush,
    output logic        wb_underflow
);

    localparam pend_cnt_t CNT_LIMIT = pend_cnt_t'(MAX_PENDING);

    word_t     regs_q [NUM_REGS];
    word_t     regs_d [NUM_REGS];
    word_t     cpsr_q;
    word_t     cpsr_d;
    word_t     pc_q;
    word_t     pc_d;
    logic      underflow_q;
    logic      underflow_d;

    pend_cnt_t          count_s [NUM_REGS];
    logic [NUM_REGS-1:0] inc_s;
    logic [NUM_REGS-1:0] dec_s;
    logic [NUM_REGS-1:0] uf_s;
    logic [NUM_REGS-1:0] busy_s;
    logic                issue_accept_s;

    // Writeback register, CPSR and PC updates; jumps take priority over advance.
    always_comb begin
        regs_d = regs_q;
        cpsr_d = cpsr_q;
        pc_d   = pc_q;
        if (wb_reg_write_en) begin
            regs_d[wb_reg_num] = wb_reg_value;
        end else begin
            regs_d = regs_q;
        end
        if (wb_cpsr_write_en) begin
            cpsr_d = wb_cpsr_value;
        end else begin
            cpsr_d = cpsr_q;
        end
        if (wb_pc_write_en) begin
            pc_d = wb_pc_value;
        end else if (pc_advance) begin
            pc_d = pc_increment(pc_q);
        end else begin
            pc_d = pc_q;
        end
    end

    // Architectural storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
            cpsr_q <= 32'h0000_0000;
            pc_q   <= RESET_PC;
        end else begin
            regs_q <= regs_d;
            cpsr_q <= cpsr_d;
            pc_q   <= pc_d;
        end
    end

    // Read ports forward a same-cycle writeback so decode never sees stale data.
    always_comb begin
        rs_value = regs_q[rs_num];
        rt_value = regs_q[rt_num];
        if (wb_reg_write_en && (wb_reg_num == rs_num)) begin
            rs_value = wb_reg_value;
        end else begin
            rs_value = regs_q[rs_num];
        end
        if (wb_reg_write_en && (wb_reg_num == rt_num)) begin
            rt_value = wb_reg_value;
        end else begin
            rt_value = regs_q[rt_num];
        end
    end

    // Busy excludes a last outstanding write that is retiring right now.
    always_comb begin
        busy_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((count_s[i] == 2'd1) && dec_s[i]) begin
                busy_s[i] = 1'b0;
            end else begin
                busy_s[i] = (count_s[i] != 2'd0);
            end
        end
    end

    // Hazard detection and scoreboard strobes.
    always_comb begin
        issue_stall = issue_valid &
                      (busy_s[rs_num] | busy_s[rt_num] |
                       (issue_writes_rd & (count_s[issue_rd_num] == CNT_LIMIT)));
        issue_accept_s = issue_valid & issue_writes_rd & ~issue_stall & ~flush;
        inc_s = '0;
        dec_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_s[i] = issue_accept_s & (issue_rd_num == reg_num_t'(i));
            dec_s[i] = wb_reg_write_en & (wb_reg_num == reg_num_t'(i));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
        pending_counter u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_s[g]),
            .dec       (dec_s[g]),
            .clr       (flush),
            .count     (count_s[g]),
            .underflow (uf_s[g])
        );
    end

    // Sticky underflow; only reset clears it.
    always_comb begin
        if (|uf_s) begin
            underflow_d = 1'b1;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Underflow flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign pc_out       = pc_q;
    assign cpsr_out     = cpsr_q;
    assign wb_underflow = underflow_q;

endmodule

// File: tb/tb_arch_state.sv
// Directed self-checking bench for arch_state: reset, bypass, hazards,
// scoreboard saturation, PC priority/wrap, flush and underflow.
module tb_arch_state;

    logic        clk;
    logic        rst;
    logic [3:0]  wb_reg_num;
    logic [31:0] wb_reg_value;
    logic        wb_reg_write_en;
    logic [31:0] wb_cpsr_value;
    logic        wb_cpsr_write_en;
    logic [31:0] wb_pc_value;
    logic        wb_pc_write_en;
    logic        pc_advance;
    logic [31:0] pc_out;
    logic [31:0] cpsr_out;
    logic [3:0]  rs_num;
    logic [3:0]  rt_num;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        issue_valid;
    logic        issue_writes_rd;
    logic [3:0]  issue_rd_num;
    logic        issue_stall;
    logic        flush;
    logic        wb_underflow;

    int errors = 0;
    int checks = 0;

    arch_state #(.RESET_PC(32'h0000_0000), .MAX_PENDING(3)) dut (
        .clk(clk), .rst(rst),
        .wb_reg_num(wb_reg_num), .wb_reg_value(wb_reg_value), .wb_reg_write_en(wb_reg_write_en),
        .wb_cpsr_value(wb_cpsr_value), .wb_cpsr_write_en(wb_cpsr_write_en),
        .wb_pc_value(wb_pc_value), .wb_pc_write_en(wb_pc_write_en), .pc_advance(pc_advance),
        .pc_out(pc_out), .cpsr_out(cpsr_out),
        .rs_num(rs_num), .rt_num(rt_num), .rs_value(rs_value), .rt_value(rt_value),
        .issue_valid(issue_valid), .issue_writes_rd(issue_writes_rd), .issue_rd_num(issue_rd_num),
        .issue_stall(issue_stall), .flush(flush), .wb_underflow(wb_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_reg_write_en = 1'b0; wb_cpsr_write_en = 1'b0; wb_pc_write_en = 1'b0;
        pc_advance = 1'b0; issue_valid = 1'b0; issue_writes_rd = 1'b0; flush = 1'b0;
        wb_reg_num = 4'd0; wb_reg_value = 32'h0; wb_cpsr_value = 32'h0; wb_pc_value = 32'h0;
        rs_num = 4'd0; rt_num = 4'd0; issue_rd_num = 4'd0;
    endtask

    task automatic issue_wr(input logic [3:0] rd);
        idle();
        issue_valid = 1'b1; issue_writes_rd = 1'b1; issue_rd_num = rd;
        #1;
        checks++;
        if (issue_stall !== 1'b0) begin
            errors++; $display("FAIL issue_r%0d: stall=%b expected 0", rd, issue_stall);
        end
        tick();
        idle();
    endtask

    task automatic retire(input logic [3:0] rd, input logic [31:0] val);
        idle();
        wb_reg_write_en = 1'b1; wb_reg_num = rd; wb_reg_value = val;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        wb_reg_write_en = 1'b1; wb_reg_num = 4'd1; wb_reg_value = 32'h1111_1111;
        wb_cpsr_write_en = 1'b1; wb_cpsr_value = 32'hF000_0000; pc_advance = 1'b1;
        tick();
        idle();
        issue_wr(4'd6);
        #1;
        checks++;
        if (pc_out !== 32'h0000_0004) begin
            errors++; $display("FAIL pre_reset_pc: got %h expected 00000004", pc_out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (pc_out !== 32'h0000_0000) begin
            errors++; $display("FAIL reset_pc: got %h expected 00000000", pc_out);
        end
        checks++;
        if (cpsr_out !== 32'h0000_0000) begin
            errors++; $display("FAIL reset_cpsr: got %h expected 00000000", cpsr_out);
        end
        checks++;
        if (wb_underflow !== 1'b0) begin
            errors++; $display("FAIL reset_underflow: got %b expected 0", wb_underflow);
        end
        for (int i = 0; i < 16; i++) begin
            rs_num = 4'(i); rt_num = 4'(15 - i);
            #1;
            checks++;
            if (rs_value !== 32'h0 || rt_value !== 32'h0) begin
                errors++; $display("FAIL reset_reg%0d: rs=%h rt=%h expected 0", i, rs_value, rt_value);
            end
        end
        rs_num = 4'd6; issue_valid = 1'b1; issue_writes_rd = 1'b1; issue_rd_num = 4'd6;
        #1;
        checks++;
        if (issue_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", issue_stall);
        end
        idle();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        issue_wr(4'd3);
        wb_reg_write_en = 1'b1; wb_reg_num = 4'd3; wb_reg_value = 32'hDEAD_BEEF;
        rs_num = 4'd3; rt_num = 4'd4;
        #1;
        checks++;
        if (rs_value !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL bypass_rs: got %h expected deadbeef", rs_value);
        end
        checks++;
        if (rt_value !== 32'h0) begin
            errors++; $display("FAIL bypass_rt_other: got %h expected 00000000", rt_value);
        end
        tick();
        wb_reg_write_en = 1'b0; rt_num = 4'd3;
        #1;
        checks++;
        if (rs_value !== 32'hDEAD_BEEF || rt_value !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL stored_r3: rs=%h rt=%h expected deadbeef", rs_value, rt_value);
        end
        idle();
    endtask

    task automatic test_hazard();
        issue_wr(4'd5);
        issue_valid = 1'b1; rs_num = 4'd5;
        #1;
        checks++;
        if (issue_stall !== 1'b1) begin
            errors++; $display("FAIL raw_stall_c1: got %b expected 1", issue_stall);
        end
        tick();
        checks++;
        if (issue_stall !== 1'b1) begin
            errors++; $display("FAIL raw_stall_c2: got %b expected 1", issue_stall);
        end
        wb_reg_write_en = 1'b1; wb_reg_num = 4'd5; wb_reg_value = 32'h0000_0055;
        #1;
        checks++;
        if (issue_stall !== 1'b0 || rs_value !== 32'h0000_0055) begin
            errors++; $display("FAIL raw_release: stall=%b rs=%h expected 0/00000055", issue_stall, rs_value);
        end
        tick();
        wb_reg_write_en = 1'b0; issue_writes_rd = 1'b1; issue_rd_num = 4'd5;
        #1;
        checks++;
        if (issue_stall !== 1'b0) begin
            errors++; $display("FAIL raw_drained: got %b expected 0", issue_stall);
        end
        idle();
    endtask

    task automatic test_saturation();
        issue_wr(4'd7);
        issue_wr(4'd7);
        issue_wr(4'd7);
        issue_valid = 1'b1; issue_writes_rd = 1'b1; issue_rd_num = 4'd7;
        #1;
        checks++;
        if (issue_stall !== 1'b1) begin
            errors++; $display("FAIL sat_fourth: got %b expected 1", issue_stall);
        end
        retire(4'd7, 32'h0000_0701);
        issue_wr(4'd7);
        issue_valid = 1'b1; issue_writes_rd = 1'b1; issue_rd_num = 4'd7;
        #1;
        checks++;
        if (issue_stall !== 1'b1) begin
            errors++; $display("FAIL sat_fifth: got %b expected 1", issue_stall);
        end
        retire(4'd7, 32'h0000_0702);
        retire(4'd7, 32'h0000_0703);
        retire(4'd7, 32'h0000_0704);
        rs_num = 4'd7; issue_valid = 1'b1;
        #1;
        checks++;
        if (issue_stall !== 1'b0 || rs_value !== 32'h0000_0704) begin
            errors++; $display("FAIL sat_drain: stall=%b r7=%h expected 0/00000704", issue_stall, rs_value);
        end
        checks++;
        if (wb_underflow !== 1'b0) begin
            errors++; $display("FAIL sat_no_underflow: got %b expected 0", wb_underflow);
        end
        idle();
    endtask

    task automatic test_pc_cpsr();
        issue_wr(4'd4);
        wb_reg_write_en = 1'b1; wb_reg_num = 4'd4; wb_reg_value = 32'h0000_0044;
        wb_cpsr_write_en = 1'b1; wb_cpsr_value = 32'h9000_0001;
        wb_pc_write_en = 1'b1; wb_pc_value = 32'hFFFF_FFFC;
        tick();
        idle();
        rs_num = 4'd4;
        #1;
        checks++;
        if (pc_out !== 32'hFFFF_FFFC || cpsr_out !== 32'h9000_0001 || rs_value !== 32'h0000_0044) begin
            errors++; $display("FAIL combo_write: pc=%h cpsr=%h r4=%h expected fffffffc/90000001/00000044", pc_out, cpsr_out, rs_value);
        end
        pc_advance = 1'b1;
        tick();
        checks++;
        if (pc_out !== 32'h0000_0000) begin
            errors++; $display("FAIL pc_wrap: got %h expected 00000000", pc_out);
        end
        wb_pc_write_en = 1'b1; wb_pc_value = 32'h0000_0100;
        tick();
        checks++;
        if (pc_out !== 32'h0000_0100) begin
            errors++; $display("FAIL pc_priority: got %h expected 00000100", pc_out);
        end
        wb_pc_write_en = 1'b0;
        tick();
        pc_advance = 1'b0;
        tick();
        checks++;
        if (pc_out !== 32'h0000_0104) begin
            errors++; $display("FAIL pc_advance_hold: got %h expected 00000104", pc_out);
        end
        idle();
    endtask

    task automatic test_flush_underflow();
        issue_wr(4'd2);
        issue_wr(4'd2);
        issue_valid = 1'b1; rs_num = 4'd2;
        #1;
        checks++;
        if (issue_stall !== 1'b1) begin
            errors++; $display("FAIL pre_flush_stall: got %b expected 1", issue_stall);
        end
        idle();
        flush = 1'b1; issue_valid = 1'b1; issue_writes_rd = 1'b1; issue_rd_num = 4'd9;
        tick();
        idle();
        issue_valid = 1'b1; rs_num = 4'd2; rt_num = 4'd9;
        #1;
        checks++;
        if (issue_stall !== 1'b0) begin
            errors++; $display("FAIL post_flush_stall: got %b expected 0", issue_stall);
        end
        checks++;
        if (wb_underflow !== 1'b0) begin
            errors++; $display("FAIL pre_underflow: got %b expected 0", wb_underflow);
        end
        retire(4'd2, 32'h0000_0022);
        rs_num = 4'd2;
        #1;
        checks++;
        if (wb_underflow !== 1'b1 || rs_value !== 32'h0000_0022) begin
            errors++; $display("FAIL underflow_set: uf=%b r2=%h expected 1/00000022", wb_underflow, rs_value);
        end
        tick();
        checks++;
        if (wb_underflow !== 1'b1) begin
            errors++; $display("FAIL underflow_sticky: got %b expected 1", wb_underflow);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_bypass();
        test_hazard();
        test_saturation();
        test_pc_cpsr();
        test_flush_underflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arch_state.md
# arch_state

Architectural state holder for the PikaCPU pipeline and the receiving end of the writeback stage's outputs. It holds sixteen 32-bit general registers, the CPSR and the PC, applying the register, CPSR and PC write requests that writeback produces. It serves two same-cycle register read ports to decode, with write-to-read bypass. It also keeps a per-register pending-write scoreboard so decode can stall on read-after-write and write-after-write hazards until writeback retires the producer.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- MAX_PENDING, 3, maximum outstanding writes per register (counter width 2 bits)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- wb_reg_num  in  4  destination register from writeback
- wb_reg_value  in  32  data to write
- wb_reg_write_en  in  1  register write strobe
- wb_cpsr_value  in  32  new CPSR (NZCV in [31:28])
- wb_cpsr_write_en  in  1  CPSR write strobe
- wb_pc_value  in  32  branch target
- wb_pc_write_en  in  1  PC write strobe (taken branch)
- pc_advance  in  1  fetch consumed an instruction; PC += 4
- pc_out  out  32  current PC
- cpsr_out  out  32  current CPSR
- rs_num, rt_num  in  4 each  decode read addresses
- rs_value, rt_value  out  32 each  read data (combinational, bypassed)
- issue_valid  in  1  decode wants to issue this cycle
- issue_writes_rd  in  1  issuing instruction writes a register
- issue_rd_num  in  4  its destination
- issue_stall  out  1  hazard; decode must hold
- flush  in  1  discard all younger in-flight instructions
- wb_underflow  out  1  sticky error: retire to a register with no pending write

## Operation
- Reset: all registers 0, CPSR 0, PC = RESET_PC, all pending counts 0, wb_underflow 0.
- Register write: on a clock edge with wb_reg_write_en, regs[wb_reg_num] <= wb_reg_value.
- CPSR write: on a clock edge with wb_cpsr_write_en, the CPSR is loaded with all 32 bits.
- Register, CPSR and PC strobes are independent; any combination may be active in the same cycle.
- PC update:
  - wb_pc_write_en has priority and loads wb_pc_value.
  - Otherwise pc_advance adds 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Read ports: rs_value = regs[rs_num], unless wb_reg_write_en and wb_reg_num == rs_num, in which case it returns wb_reg_value. rt_value follows the same rule.
- Scoreboard: one saturating counter per register.
  - issue_accept = issue_valid & issue_writes_rd & ~issue_stall & ~flush increments count[issue_rd_num].
  - wb_reg_write_en decrements count[wb_reg_num].
  - Both on the same register in the same cycle: count unchanged.
  - Retire on count 0: count stays 0 and wb_underflow sets; only rst clears it. The register data is still written.
- Hazard: a register is busy if count != 0, excluding a count of exactly 1 whose retire is presented this cycle.
  - issue_stall = issue_valid & (busy(rs_num) | busy(rt_num) | (issue_writes_rd & count[issue_rd_num] == MAX_PENDING)).
- flush: all counts are zeroed at the next edge and any same-cycle issue is dropped. A same-cycle retire still writes its data.

## Timing
- Reads and issue_stall are combinational from the inputs and current state; zero-cycle latency.
- All state updates take effect at the next rising edge; outputs reflect them one cycle after the strobe.
- Asynchronous reset acts immediately; a write in progress when rst asserts is lost.
- No handshake on the writeback side: every strobe is accepted unconditionally.

## Structure
- Shared package pika_pkg holds:
  - REG_NUM_W = 4, NUM_REGS = 16, WORD_W = 32, PC_STEP = 4
  - CPSR bit indices N = 31, Z = 30, C = 29, V = 28
  - typedef word_t and reg_num_t
- One sub-module, pending_counter: a 2-bit saturating up/down counter with clear and underflow flag, instantiated NUM_REGS times.

## Test plan
- Reset then read: assert rst mid-run. Response: pc_out = RESET_PC, rs_value = 0 for all registers, cpsr_out = 0, issue_stall = 0.
- Bypass: write r3 = 0xDEAD_BEEF while rs_num = 3 in the same cycle. Response: rs_value = 0xDEAD_BEEF that cycle, and the next cycle from storage.
- Hazard: issue with rd = r5, then next cycle issue_valid with rs_num = 5. Response: issue_stall = 1 until the r5 retire cycle, where it drops to 0 via bypass.
- Saturation: three issues to r7 without retire, then a fourth. Response: issue_stall = 1 on the fourth. Retire once, and the fourth is accepted.
- PC priority and wrap:
  - PC = 0xFFFF_FFFC with pc_advance gives 0.
  - pc_advance together with wb_pc_write_en = 0x100 gives 0x100.
- Flush and underflow:
  - Two pending on r2, then flush. Response: next cycle no stall on r2.
  - A later retire to r2 writes the data and sets wb_underflow = 1.
